// File: rtl/bin_to_bcd_seq.sv
// Sequential 14-bit binary to 4-digit BCD converter (shift-and-add-3).
// One bit per clock in OP; out-of-range inputs saturate to 9999 with ovf.

module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module bin_to_bcd_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        ready,
  output logic        done_tick,
  output logic [15:0] bcd,
  output logic        ovf
);
  localparam int NUM_DIG = 4;
  localparam int BIN_W   = 14;

  typedef enum logic [1:0] {IDLE, OP, DONE} state_t;

  state_t                      state, state_nxt;
  logic [BIN_W-1:0]            sh;
  logic [NUM_DIG-1:0][3:0]     wrk, wrk_adj;
  logic [3:0]                  cnt;
  logic [15:0]                 adj_flat, wrk_shift;
  logic                        accept, in_ovf, last_shift;

  // Per-digit add-3 correction ahead of the shift.
  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
    bcd_add3 u_add3 (.din(wrk[g]), .dout(wrk_adj[g]));
  end

  assign adj_flat   = wrk_adj;
  assign wrk_shift  = {adj_flat[14:0], sh[BIN_W-1]};
  assign accept     = (state == IDLE) && start;
  assign in_ovf     = bin > 14'd9999;
  assign last_shift = (state == OP) && (cnt == 4'd1);

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done_tick = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = in_ovf ? DONE : OP;
      end
      OP:   if (cnt == 4'd1) state_nxt = DONE;
      DONE: begin
        done_tick = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bcd   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept && in_ovf) begin
        bcd <= 16'h9999;
        ovf <= 1'b1;
      end else if (last_shift) begin
        bcd <= wrk_shift;
        ovf <= 1'b0;
      end
    end
  end

  // Working registers need no reset: every accepted start reloads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      sh  <= bin;
      wrk <= '0;
      cnt <= 4'(BIN_W);
    end else if (state == OP) begin
      wrk <= wrk_shift;
      sh  <= {sh[BIN_W-2:0], 1'b0};
      cnt <= cnt - 4'd1;
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: latency, results, overflow, start
// blocking during conversion, reset abort, and a strided value sweep.

module tb_bin_to_bcd_seq;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [13:0] bin;
  logic        ready, done_tick, ovf;
  logic [15:0] bcd;

  int checks = 0;
  int failures = 0;

  bin_to_bcd_seq dut (
    .clk(clk), .reset(reset), .start(start), .bin(bin),
    .ready(ready), .done_tick(done_tick), .bcd(bcd), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_bcd(input int v);
    if (v > 9999) return 16'h9999;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Starts a conversion, scrambles bin after the sampling edge, and checks
  // latency (negedges after the start edge), result, hold and ready return.
  task automatic convert(input int v);
    logic [15:0] prev_bcd, exp_bcd;
    logic        prev_ovf, held;
    int          k;
    exp_bcd = ref_bcd(v);
    @(negedge clk);
    chk("ready_before", ready, 1'b1);
    prev_bcd = bcd;
    prev_ovf = ovf;
    start = 1'b1;
    bin   = 14'(v);
    @(negedge clk);
    start = 1'b0;
    bin   = ~14'(v);
    held  = 1'b1;
    k     = 1;
    while (!done_tick && k < 40) begin
      if (bcd !== prev_bcd || ovf !== prev_ovf || ready !== 1'b0) held = 1'b0;
      @(negedge clk);
      k++;
    end
    chk("done_seen", done_tick, 1'b1);
    chk("latency", k, (v > 9999) ? 1 : 15);
    chk("hold_in_op", held, 1'b1);
    chk("bcd", bcd, exp_bcd);
    chk("ovf", ovf, (v > 9999) ? 1'b1 : 1'b0);
    @(negedge clk);
    chk("single_pulse", done_tick, 1'b0);
    chk("ready_after", ready, 1'b1);
    chk("bcd_kept", bcd, exp_bcd);
  endtask

  initial begin
    int nd, t1, t2;
    logic [15:0] b1, b2;
    reset = 1'b1; start = 1'b0; bin = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_bcd", bcd, 16'h0000);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done_tick, 1'b0);

    convert(1234);
    convert(0);
    convert(9999);
    convert(10000);
    convert(16383);
    convert(42);
    convert(9998);

    // start held high through a conversion: second start waits for ready
    @(negedge clk);
    start = 1'b1; bin = 14'd5678;
    @(negedge clk);
    bin = 14'd1111;
    nd = 0; t1 = 0; t2 = 0; b1 = '0; b2 = '0;
    for (int k = 1; k <= 36; k++) begin
      if (done_tick) begin
        nd++;
        if (nd == 1) begin t1 = k; b1 = bcd; end
        else begin t2 = k; b2 = bcd; end
      end
      if (k == 20) start = 1'b0;
      @(negedge clk);
    end
    chk("b2b_count", nd, 2);
    chk("b2b_t1", t1, 15);
    chk("b2b_bcd1", b1, 16'h5678);
    chk("b2b_t2", t2, 31);
    chk("b2b_bcd2", b2, 16'h1111);

    // reset mid-conversion abandons it
    convert(250);
    @(negedge clk);
    start = 1'b1; bin = 14'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_bcd", bcd, 16'h0000);
    chk("abort_ready", ready, 1'b1);
    chk("abort_ovf", ovf, 1'b0);
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      if (done_tick) nd++;
      @(negedge clk);
    end
    chk("abort_no_done", nd, 0);
    convert(42);

    // reset wins over start at the same edge
    @(negedge clk);
    reset = 1'b1; start = 1'b1; bin = 14'd123;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("prio_ready", ready, 1'b1);
    chk("prio_bcd", bcd, 16'h0000);
    @(negedge clk);
    chk("prio_no_done", done_tick, 1'b0);

    for (int v = 3; v < 16384; v += 97) convert(v);
    convert(16382);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
